// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: drives a synchronous-read memory and hides its 1-cycle latency
// behind a 2-entry {instr, pc} buffer with valid/ready output and branch redirect flush.
module instr_fetch_unit #(
   parameter int unsigned          DATA_W   = 16,
   parameter int unsigned          ADDR_W   = 8,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc
);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic              r_inflight_valid;
   logic [DATA_W-1:0] r_fifo_instr [2];
   logic [ADDR_W-1:0] r_fifo_pc    [2];
   logic [1:0]        r_count;

   logic              w_instr_valid;
   logic              w_pop;
   logic              w_push;
   logic              w_issue;
   logic [2:0]        w_credit;

   always_comb begin
      w_instr_valid = (r_count != 2'd0) & ~redirect_valid;
      w_pop         = w_instr_valid & instr_ready;
      w_push        = r_inflight_valid & ~redirect_valid;
      // Buffered + in-flight words after this edge's pop must leave room for a new issue.
      w_credit      = {1'b0, r_count} + {2'b00, r_inflight_valid} - {2'b00, w_pop};
      w_issue       = ~redirect_valid & (w_credit < 3'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc             <= RESET_PC;
         r_inflight_valid <= 1'b0;
         r_inflight_pc    <= '0;
      end else if (redirect_valid) begin
         r_pc             <= redirect_pc;
         r_inflight_valid <= 1'b0;
      end else if (w_issue) begin
         r_pc             <= r_pc + ADDR_W'(1);
         r_inflight_valid <= 1'b1;
         r_inflight_pc    <= r_pc;
      end else begin
         r_inflight_valid <= 1'b0;
      end
   end

   // Shifting buffer: entry 0 is always the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count         <= 2'd0;
         r_fifo_instr[0] <= '0;
         r_fifo_instr[1] <= '0;
         r_fifo_pc[0]    <= '0;
         r_fifo_pc[1]    <= '0;
      end else if (redirect_valid) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               r_fifo_instr[r_count[0]] <= mem_dout;
               r_fifo_pc[r_count[0]]    <= r_inflight_pc;
               r_count                  <= r_count + 2'd1;
            end
            2'b01: begin
               r_fifo_instr[0] <= r_fifo_instr[1];
               r_fifo_pc[0]    <= r_fifo_pc[1];
               r_count         <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_fifo_instr[0] <= mem_dout;
                  r_fifo_pc[0]    <= r_inflight_pc;
               end else begin
                  r_fifo_instr[0] <= r_fifo_instr[1];
                  r_fifo_pc[0]    <= r_fifo_pc[1];
                  r_fifo_instr[1] <= mem_dout;
                  r_fifo_pc[1]    <= r_inflight_pc;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_read_addr = r_pc;
   assign instr_valid   = w_instr_valid;
   assign instr         = r_fifo_instr[0];
   assign instr_pc      = r_fifo_pc[0];

   always @(posedge clk) begin
      if (rst_n) begin
         assert (r_count <= 2'd2);
         assert (({1'b0, r_count} + {2'b00, r_inflight_valid}) <= 3'd2);
         assert (!(w_push && (r_count == 2'd2) && !w_pop));
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (RESET_PC 0 and 0xFE), each with a
// synchronous-read memory model feeding mem_dout.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, rst_n_b;
   logic [7:0]  mem_read_addr, mem_read_addr_b;
   logic [15:0] mem_dout, mem_dout_b;
   logic        redirect_valid, redirect_valid_b;
   logic [7:0]  redirect_pc, redirect_pc_b;
   logic        instr_valid, instr_valid_b;
   logic        instr_ready, instr_ready_b;
   logic [15:0] instr, instr_b;
   logic [7:0]  instr_pc, instr_pc_b;

   logic [15:0] mem  [256];
   logic [15:0] mem1 [256];

   int n_checks = 0;
   int n_errors = 0;
   int e = 0;

   always @(posedge clk) mem_dout   <= mem[mem_read_addr];
   always @(posedge clk) mem_dout_b <= mem1[mem_read_addr_b];

   instr_fetch_unit #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'h00)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_read_addr  (mem_read_addr),
      .mem_dout       (mem_dout),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   instr_fetch_unit #(.DATA_W(16), .ADDR_W(8), .RESET_PC(8'hFE)) u_dut_b (
      .clk            (clk),
      .rst_n          (rst_n_b),
      .mem_read_addr  (mem_read_addr_b),
      .mem_dout       (mem_dout_b),
      .redirect_valid (redirect_valid_b),
      .redirect_pc    (redirect_pc_b),
      .instr_valid    (instr_valid_b),
      .instr_ready    (instr_ready_b),
      .instr          (instr_b),
      .instr_pc       (instr_pc_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Expects an unbroken run of words A000+e at pc e, one per cycle, with instr_ready high.
   task automatic stream(input int n);
      for (int i = 0; i < n; i++) begin
         chk("stream_valid", 32'(instr_valid), 32'd1);
         chk("stream_instr", 32'(instr), 32'h0000A000 + 32'(e));
         chk("stream_pc", 32'(instr_pc), 32'(e));
         e++;
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]  = 16'hA000 + 16'(i);
         mem1[i] = 16'h0000;
      end
      mem1[8'hFE] = 16'h1111;
      mem1[8'hFF] = 16'h2222;
      mem1[8'h00] = 16'h3333;
      mem1[8'h01] = 16'h4444;

      rst_n = 1'b1; rst_n_b = 1'b1;
      redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b1;
      redirect_valid_b = 1'b0; redirect_pc_b = 8'h00; instr_ready_b = 1'b0;
      #1;
      rst_n = 1'b0; rst_n_b = 1'b0;
      #1;
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
      chk("rst_addr", 32'(mem_read_addr), 32'h00);
      chk("rst_addr_b", 32'(mem_read_addr_b), 32'hFE);
      chk("rst_valid_b", 32'(instr_valid_b), 32'd0);

      // Release between edges; first issue edge follows, data is buffered one edge later.
      @(posedge clk); #2;
      rst_n = 1'b1;
      tick();
      chk("lat_valid_low", 32'(instr_valid), 32'd0);
      chk("lat_addr", 32'(mem_read_addr), 32'h01);
      tick();
      e = 0;
      stream(6);

      // Backpressure: head 6 holds, fetch address frozen at head+2.
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(instr_valid), 32'd1);
         chk("bp_instr", 32'(instr), 32'h0000A006);
         chk("bp_pc", 32'(instr_pc), 32'h06);
         chk("bp_addr", 32'(mem_read_addr), 32'h08);
         tick();
      end
      instr_ready = 1'b1;
      #1;
      stream(6);

      // Single-cycle redirect to 0x40.
      redirect_valid = 1'b1; redirect_pc = 8'h40;
      #1;
      chk("redir_valid_r0", 32'(instr_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("redir_valid_r1", 32'(instr_valid), 32'd0);
      tick();
      chk("redir_valid_r2", 32'(instr_valid), 32'd0);
      tick();
      e = 32'h40;
      stream(4);

      // Buffer two words, then assert reset asynchronously mid-cycle.
      instr_ready = 1'b0;
      tick();
      tick();
      chk("pre_rst_valid", 32'(instr_valid), 32'd1);
      chk("pre_rst_instr", 32'(instr), 32'h0000A044);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(instr_valid), 32'd0);
      chk("async_addr", 32'(mem_read_addr), 32'h00);
      chk("async_instr", 32'(instr), 32'd0);
      chk("async_pc", 32'(instr_pc), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      instr_ready = 1'b1;
      tick();
      chk("rerst_valid_low", 32'(instr_valid), 32'd0);
      tick();
      e = 0;
      stream(4);

      // Two back-to-back redirects while a handshake would otherwise complete.
      redirect_valid = 1'b1; redirect_pc = 8'h10;
      #1;
      chk("dbl_valid_r0", 32'(instr_valid), 32'd0);
      tick();
      redirect_pc = 8'h20;
      #1;
      chk("dbl_valid_r1", 32'(instr_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("dbl_valid_r2", 32'(instr_valid), 32'd0);
      tick();
      chk("dbl_valid_r3", 32'(instr_valid), 32'd0);
      tick();
      e = 32'h20;
      stream(3);

      // Wrap-around from RESET_PC 0xFE.
      rst_n_b = 1'b1;
      instr_ready_b = 1'b1;
      tick();
      chk("wrap_valid_low", 32'(instr_valid_b), 32'd0);
      tick();
      chk("wrap_pc0", 32'(instr_pc_b), 32'hFE);
      chk("wrap_instr0", 32'(instr_b), 32'h1111);
      tick();
      chk("wrap_pc1", 32'(instr_pc_b), 32'hFF);
      chk("wrap_instr1", 32'(instr_b), 32'h2222);
      tick();
      chk("wrap_pc2", 32'(instr_pc_b), 32'h00);
      chk("wrap_instr2", 32'(instr_b), 32'h3333);
      tick();
      chk("wrap_pc3", 32'(instr_pc_b), 32'h01);
      chk("wrap_instr3", 32'(instr_b), 32'h4444);
      chk("wrap_valid", 32'(instr_valid_b), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
